feature_fetch_ctrl: RTL and testbench
=====================================

# feature_fetch_ctrl

Sequencer for the per-feature weight ROMs of the cascade classifier. It accepts a stage descriptor (first feature index, feature count) and walks the ROM address range, driving `rom_en`/`rom_addr`. It absorbs the ROM's 1-cycle registered read latency and presents one weight per feature to the downstream feature evaluator on a valid/ready stream with full backpressure. It sits between the stage scheduler and the weights ROMs / feature evaluator.

## Interface
- `W_ADDR`, 8: ROM address width; also the width of feature index and count.
- `W_DATA`, 3: weight word width.
- `N_FEATURES`, 136: number of valid ROM entries, addresses 0..N_FEATURES-1.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  stage descriptor valid.
- `start_ready`  out  1  descriptor accepted when both high; high only in IDLE.
- `start_base`  in  W_ADDR  first feature address.
- `start_count`  in  W_ADDR+1  number of features in the stage (0 allowed).
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  W_ADDR  ROM read address.
- `rom_data`  in  W_DATA  ROM output, valid the cycle after `rom_en`.
- `feat_valid`  out  1  weight available.
- `feat_ready`  in  1  downstream accepts.
- `feat_weight`  out  W_DATA  weight of the current feature.
- `feat_idx`  out  W_ADDR  ROM address the weight came from.
- `feat_last`  out  1  current feature is the last of the stage.
- `busy`  out  1  descriptor in progress (FETCH or DRAIN).
- `done`  out  1  one-cycle pulse, stage complete.
- `err`  out  1  one-cycle pulse, descriptor rejected.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: `start_ready`=1. On accept:
  - count=0: `done` pulses on the next cycle. State stays IDLE.
  - base+count > N_FEATURES, computed at W_ADDR+2 bits with no wrap: `err` pulses on the next cycle. No ROM reads. State stays IDLE.
  - Otherwise: latch next_addr=base and remaining=count, then go to FETCH.
- FETCH: issue a read (`rom_en`=1, `rom_addr`=next_addr) whenever credits allow. Credits: in-flight reads plus buffered entries must be at most 2. Each issue increments next_addr and decrements remaining. After the read with remaining=1 is issued, go to DRAIN.
- Buffer: 2-entry FIFO {weight, idx, last}. The returning `rom_data` is written the cycle after issue, with idx and last delayed alongside it. `last` is 1 when the read was issued with remaining=1.
- Stream outputs come from the FIFO head. `feat_valid` = FIFO not empty. Payload holds stable while `feat_valid`=1 and `feat_ready`=0.
- DRAIN: issue no reads. When a handshake occurs with `feat_last`=1, go to IDLE and pulse `done` on that same cycle.
- `rom_en`=0 whenever no read is issued. `rom_addr` holds its last value.
- `busy` = state != IDLE.

## Timing
- Reset values: `start_ready`=0 (registered; first goes to 1 in the cycle after `rst` deasserts); state IDLE. All of `rom_en`, `feat_valid`, `feat_last`, `busy`, `done`, `err` are 0. `rom_addr`, `feat_weight` and `feat_idx` are 0. FIFO is empty, counters are 0.
- Accept at edge T: first `rom_en` in cycle T+1, first `feat_valid` in cycle T+2.
- With `feat_ready` held at 1: one feature per cycle; the last handshake occurs in cycle T+1+count.
- Backpressure: during a stall, at most 2 reads are outstanding or buffered. No data is ever dropped or duplicated. Issue resumes in the cycle after a handshake frees a credit.
- `start_ready` deasserts in the cycle after an accept. It reasserts in the cycle after `done` or `err`.
- Ignored inputs: `start_valid` outside IDLE, and `feat_ready` while `feat_valid`=0.
- Reset mid-stage: all state clears immediately (asynchronous). No `done` is produced for the aborted stage.
- Address arithmetic never wraps, because the range check guarantees last address ≤ N_FEATURES-1.

## Structure
- Shared package `cascade_pkg`:
  - `N_FEATURES`
  - FSM enum `fetch_state_t`
  - struct `feat_entry_t` {weight, idx, last}
- Sub-module `feat_skid_fifo`: 2-entry FIFO, parameterised on the entry type. It is the only natural split.
- The ROM is external; the controller contains no ROM instance.

## Test plan
- After reset, base=0x20, count=4, `feat_ready`=1: `rom_addr` 0x20..0x23 on consecutive cycles. Output weights 0,0,0,2 with idx 0x20..0x23. `feat_last` only on idx 0x23. `done` pulses in the same cycle as that last handshake.
- base=0x78, count=3, `feat_ready` low for 5 cycles then high: at most 2 reads issued during the stall. Weights 2,2,2 delivered in order with payload stable during the stall.
- count=0: `done` pulses one cycle after accept. No `rom_en`, no `feat_valid`.
- base=0x86, count=3: `err` pulses one cycle after accept. No `rom_en`. Next, base=0x85, count=3 is accepted normally (last idx 0x87).
- `rst` asserted two cycles into base=0x30, count=10: all outputs return to reset values immediately. No `done`. A new descriptor is accepted after release.
- Back-to-back: stage base=0x6C, count=3, then base=0x46, count=1 presented immediately. The second is accepted the cycle after the first `done`. Weights 0,2,2 then 2.

Source files
------------

// File: rtl/cascade_pkg.sv
// Shared types and constants for the cascade classifier feature path.
// Provides the ROM geometry, the fetch controller FSM encoding and the
// buffered feature entry carried from the weight ROM to the evaluator.
package cascade_pkg;

  localparam int unsigned W_ADDR     = 8;
  localparam int unsigned W_DATA     = 3;
  localparam int unsigned N_FEATURES = 136;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [W_DATA-1:0] weight;
    logic [W_ADDR-1:0] idx;
    logic              last;
  } feat_entry_t;

endpackage

// File: rtl/feat_skid_fifo.sv
// Two-entry FIFO with fall-through when empty, parameterised on entry type.
// Ports:
//   clk, rst            clock, async active-high reset
//   wr_valid, wr_data   entry arriving this cycle (always accepted)
//   rd_valid, rd_ready  head handshake
//   rd_data             head entry, all zeros while rd_valid is low
//   count               number of stored entries (0..2)
module feat_skid_fifo #(
  parameter type entry_t = logic
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  entry_t     wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output entry_t     rd_data,
  output logic [1:0] count
);

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       empty;
  logic       pop;
  logic       store;
  logic       unload;

  // An arriving entry is presented directly when storage is empty; it is
  // only stored if it is not consumed in the same cycle.
  always_comb begin
    empty    = (cnt == 2'd0);
    rd_valid = !empty || wr_valid;
    pop      = rd_valid && rd_ready;
    store    = wr_valid && !(empty && pop);
    unload   = pop && !empty;
    if (!empty) begin
      rd_data = mem[rd_ptr];
    end else if (wr_valid) begin
      rd_data = wr_data;
    end else begin
      rd_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (unload) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({store, unload})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;

endmodule

// File: rtl/feature_fetch_ctrl.sv
// Weight ROM fetch sequencer: walks a stage's feature range, absorbs the
// ROM's one-cycle read latency and streams one weight per feature.
// Ports:
//   clk, rst                      clock, async active-high reset
//   start_valid/ready/base/count  stage descriptor handshake
//   rom_en, rom_addr, rom_data    external weight ROM (1-cycle read)
//   feat_valid/ready/weight/idx/last  feature stream to the evaluator
//   busy, done, err               stage status
module feature_fetch_ctrl
  import cascade_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [W_ADDR-1:0] start_base,
  input  logic [W_ADDR:0]   start_count,
  output logic              rom_en,
  output logic [W_ADDR-1:0] rom_addr,
  input  logic [W_DATA-1:0] rom_data,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [W_DATA-1:0] feat_weight,
  output logic [W_ADDR-1:0] feat_idx,
  output logic              feat_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned W_SUM = W_ADDR + 2;

  fetch_state_t      state_q, state_d;
  logic [W_ADDR-1:0] next_addr_q;
  logic [W_ADDR-1:0] last_addr_q;
  logic [W_ADDR:0]   remaining_q;
  logic              pend_q;
  logic [W_ADDR-1:0] pend_idx_q;
  logic              pend_last_q;
  logic              start_ready_q;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              range_bad;
  logic              credit_ok;
  logic              issue;
  logic              hs;
  logic              done_c;
  logic [1:0]        fifo_cnt;
  logic              head_valid;
  feat_entry_t       wr_entry;
  feat_entry_t       head;

  // Descriptor qualification; range check is widened so it cannot wrap.
  always_comb begin
    accept    = start_valid && start_ready_q && (state_q == ST_IDLE);
    range_bad = (W_SUM'(start_base) + W_SUM'(start_count)) > W_SUM'(N_FEATURES);
  end

  // Reads in flight plus stored entries never exceed the FIFO depth.
  always_comb begin
    credit_ok = ({1'b0, pend_q} + fifo_cnt) < 2'd2;
    hs        = head_valid && feat_ready;
    done_c    = (state_q == ST_DRAIN) && hs && head.last;
  end

  // Next-state and issue decode.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (start_count == '0) begin
            done_d = 1'b1;
          end else if (range_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining_q == (W_ADDR+1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address walk, read-latency tracking and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr_q   <= '0;
      last_addr_q   <= '0;
      remaining_q   <= '0;
      pend_q        <= 1'b0;
      pend_idx_q    <= '0;
      pend_last_q   <= 1'b0;
      start_ready_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      start_ready_q <= (state_d == ST_IDLE) && !accept;
      done_q        <= done_d;
      err_q         <= err_d;
      if (accept) begin
        next_addr_q <= start_base;
        remaining_q <= start_count;
      end else if (issue) begin
        next_addr_q <= next_addr_q + W_ADDR'(1);
        remaining_q <= remaining_q - (W_ADDR+1)'(1);
      end
      if (issue) begin
        last_addr_q <= next_addr_q;
        pend_idx_q  <= next_addr_q;
        pend_last_q <= (remaining_q == (W_ADDR+1)'(1));
      end
      pend_q <= issue;
    end
  end

  // ROM data returns one cycle after issue, tagged with its index and last flag.
  always_comb begin
    wr_entry = '{weight: rom_data, idx: pend_idx_q, last: pend_last_q};
  end

  feat_skid_fifo #(
    .entry_t(feat_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(pend_q),
    .wr_data (wr_entry),
    .rd_valid(head_valid),
    .rd_ready(feat_ready),
    .rd_data (head),
    .count   (fifo_cnt)
  );

  assign start_ready = start_ready_q;
  assign rom_en      = issue;
  assign rom_addr    = issue ? next_addr_q : last_addr_q;
  assign feat_valid  = head_valid;
  assign feat_weight = head.weight;
  assign feat_idx    = head.idx;
  assign feat_last   = head.last;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q || done_c;
  assign err         = err_q;

endmodule

// File: tb/tb_feature_fetch_ctrl.sv
// Self-checking bench for feature_fetch_ctrl with a registered ROM model.
module tb_feature_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] start_base;
  logic [8:0] start_count;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [2:0] rom_data = '0;
  logic       feat_valid;
  logic       feat_ready;
  logic [2:0] feat_weight;
  logic [7:0] feat_idx;
  logic       feat_last;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [2:0] rom_mem [256];

  typedef struct {
    logic       sv;
    logic [7:0] base;
    logic [8:0] cnt;
    logic       rdy;
    logic       sr;
    logic       en;
    logic [7:0] addr;
    logic       fv;
    logic [2:0] w;
    logic [7:0] idx;
    logic       last;
    logic       dn;
    logic       er;
    logic       bz;
  } vec_t;

  vec_t vq[$];
  int   got_idx[$];
  int   got_w[$];
  int   got_last[$];
  logic got_done;

  feature_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .start_base (start_base),
    .start_count(start_count),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_weight(feat_weight),
    .feat_idx   (feat_idx),
    .feat_last  (feat_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Registered ROM: data appears the cycle after rom_en.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int sv, input int base, input int cnt, input int rdy,
                              input int sr, input int en, input int addr, input int fv,
                              input int w, input int idx, input int last, input int dn,
                              input int er, input int bz);
    vec_t v;
    v.sv = 1'(sv);   v.base = 8'(base); v.cnt = 9'(cnt); v.rdy = 1'(rdy);
    v.sr = 1'(sr);   v.en = 1'(en);     v.addr = 8'(addr); v.fv = 1'(fv);
    v.w = 3'(w);     v.idx = 8'(idx);   v.last = 1'(last); v.dn = 1'(dn);
    v.er = 1'(er);   v.bz = 1'(bz);
    return v;
  endfunction

  task automatic check_reset(input string p);
    check({p, ".start_ready"}, 32'(start_ready), 0);
    check({p, ".rom_en"},      32'(rom_en), 0);
    check({p, ".rom_addr"},    32'(rom_addr), 0);
    check({p, ".feat_valid"},  32'(feat_valid), 0);
    check({p, ".feat_weight"}, 32'(feat_weight), 0);
    check({p, ".feat_idx"},    32'(feat_idx), 0);
    check({p, ".feat_last"},   32'(feat_last), 0);
    check({p, ".busy"},        32'(busy), 0);
    check({p, ".done"},        32'(done), 0);
    check({p, ".err"},         32'(err), 0);
  endtask

  // Drain with feat_ready high until done, recording every handshake.
  task automatic collect(input string p, input int budget);
    int n;
    got_idx.delete(); got_w.delete(); got_last.delete();
    got_done = 1'b0;
    n = 0;
    while (n < budget && !got_done) begin
      tick();
      start_valid = 1'b0;
      feat_ready  = 1'b1;
      @(negedge clk);
      if (feat_valid) begin
        got_idx.push_back(int'(feat_idx));
        got_w.push_back(int'(feat_weight));
        got_last.push_back(int'(feat_last));
      end
      if (done) got_done = 1'b1;
      n++;
    end
    check({p, ".done_seen"}, 32'(got_done), 1);
  endtask

  task automatic run_random(input int n);
    for (int d = 0; d < n; d++) begin
      logic [7:0] b;
      logic [8:0] c;
      int         kind;
      int         q[$];
      int         issued, taken, cyc, r;
      logic       fin, pstall, pl;
      logic [2:0] pw;
      logic [7:0] pi;

      r = int'($urandom_range(0, 7));
      c = (r == 0) ? 9'd0 : 9'($urandom_range(1, 12));
      if (r == 1)      b = 8'(136 - int'(c));
      else if (r == 2) b = 8'(137 - int'(c));
      else             b = 8'($urandom_range(0, 140));

      q.delete();
      if (c == 0) kind = 0;
      else if (int'(b) + int'(c) > 136) kind = 1;
      else begin
        kind = 2;
        for (int i = 0; i < int'(c); i++) q.push_back(int'(b) + i);
      end

      tick();
      start_valid = 1'b1; start_base = b; start_count = c;
      feat_ready  = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      check("rnd.start_ready", 32'(start_ready), 1);

      issued = 0; taken = 0; cyc = 1; fin = 1'b0; pstall = 1'b0;
      pw = '0; pi = '0; pl = 1'b0;
      while (cyc <= 300 && !fin) begin
        tick();
        start_valid = ($urandom_range(0, 1) == 1);
        start_base  = 8'($urandom_range(0, 255));
        start_count = 9'($urandom_range(0, 20));
        feat_ready  = ($urandom_range(0, 9) < 6);
        @(negedge clk);
        if (kind != 2) begin
          check("rnd.no_read", 32'(rom_en), 0);
          check("rnd.no_beat", 32'(feat_valid), 0);
        end else begin
          if (rom_en) issued++;
          check("rnd.credit", 32'((issued - taken) <= 2), 1);
        end
        if (pstall) begin
          check("rnd.stall_valid", 32'(feat_valid), 1);
          check("rnd.stall_weight", 32'(feat_weight), 32'(pw));
          check("rnd.stall_idx", 32'(feat_idx), 32'(pi));
          check("rnd.stall_last", 32'(feat_last), 32'(pl));
        end
        if (feat_valid && feat_ready) begin
          if (q.size() == 0) begin
            check("rnd.extra_beat", 32'(feat_idx), 32'hFFFF);
          end else begin
            check("rnd.idx", 32'(feat_idx), 32'(q[0]));
            check("rnd.weight", 32'(feat_weight), 32'(rom_mem[q[0]]));
            check("rnd.last", 32'(feat_last), 32'(q.size() == 1));
            check("rnd.done_on_last", 32'(done), 32'(q.size() == 1));
            void'(q.pop_front());
            taken++;
          end
        end
        pstall = feat_valid && !feat_ready;
        pw = feat_weight; pi = feat_idx; pl = feat_last;
        if (done || err) begin
          fin = 1'b1;
          check("rnd.done_kind", 32'(done), 32'(kind != 1));
          check("rnd.err_kind", 32'(err), 32'(kind == 1));
          check("rnd.all_delivered", 32'(q.size()), 0);
          if (kind != 2) check("rnd.status_latency", 32'(cyc), 1);
        end
        cyc++;
      end
      if (!fin) check("rnd.timeout", 32'(fin), 1);

      tick();
      start_valid = 1'b0;
      @(negedge clk);
      check("rnd.ready_again", 32'(start_ready), 1);
      check("rnd.idle", 32'(busy), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads;

    for (int a = 0; a < 256; a++) rom_mem[a] = 3'((a * 3) ^ (a >> 2));
    rom_mem[8'h20] = 3'd0; rom_mem[8'h21] = 3'd0; rom_mem[8'h22] = 3'd0; rom_mem[8'h23] = 3'd2;
    rom_mem[8'h78] = 3'd2; rom_mem[8'h79] = 3'd2; rom_mem[8'h7A] = 3'd2;
    rom_mem[8'h6C] = 3'd0; rom_mem[8'h6D] = 3'd2; rom_mem[8'h6E] = 3'd2;
    rom_mem[8'h46] = 3'd2;
    rom_mem[8'h85] = 3'd1; rom_mem[8'h86] = 3'd5; rom_mem[8'h87] = 3'd7;

    rst = 1'b1; start_valid = 1'b0; start_base = '0; start_count = '0; feat_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rel.start_ready_low", 32'(start_ready), 0);
    tick();
    @(negedge clk);
    check("rel.start_ready_high", 32'(start_ready), 1);

    // Per-cycle vectors: sv,base,cnt,rdy | sr,en,addr,fv,w,idx,last,done,err,busy
    vq.push_back(mk(1,'h20,4,1, 1,0,'h00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,    0,1,'h20,0,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,1,'h21,1,0,'h20,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,1,'h22,1,0,'h21,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,1,'h23,1,0,'h22,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,0,'h23,1,2,'h23,1,1,0,1));
    vq.push_back(mk(0,0,0,1,    1,0,'h23,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h10,0,1, 1,0,'h23,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,    0,0,'h23,0,0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,1,    1,0,'h23,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h86,3,1, 1,0,'h23,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,    0,0,'h23,0,0,0,0,0,1,0));
    vq.push_back(mk(1,'h85,3,1, 1,0,'h23,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,    0,1,'h85,0,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,1,'h86,1,1,'h85,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,1,'h87,1,5,'h86,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,0,'h87,1,7,'h87,1,1,0,1));
    vq.push_back(mk(0,0,0,1,    1,0,'h87,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h6C,3,1, 1,0,'h87,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h46,1,1, 0,1,'h6C,0,0,0,0,0,0,1));
    vq.push_back(mk(1,'h46,1,1, 0,1,'h6D,1,0,'h6C,0,0,0,1));
    vq.push_back(mk(1,'h46,1,1, 0,1,'h6E,1,2,'h6D,0,0,0,1));
    vq.push_back(mk(1,'h46,1,1, 0,0,'h6E,1,2,'h6E,1,1,0,1));
    vq.push_back(mk(1,'h46,1,1, 1,0,'h6E,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,    0,1,'h46,0,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,1,    0,0,'h46,1,2,'h46,1,1,0,1));
    vq.push_back(mk(0,0,0,1,    1,0,'h46,0,0,0,0,0,0,0));

    foreach (vq[i]) begin
      tick();
      start_valid = vq[i].sv; start_base = vq[i].base;
      start_count = vq[i].cnt; feat_ready = vq[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d.start_ready", i), 32'(start_ready), 32'(vq[i].sr));
      check($sformatf("vec%0d.rom_en", i),      32'(rom_en), 32'(vq[i].en));
      check($sformatf("vec%0d.rom_addr", i),    32'(rom_addr), 32'(vq[i].addr));
      check($sformatf("vec%0d.feat_valid", i),  32'(feat_valid), 32'(vq[i].fv));
      check($sformatf("vec%0d.done", i),        32'(done), 32'(vq[i].dn));
      check($sformatf("vec%0d.err", i),         32'(err), 32'(vq[i].er));
      check($sformatf("vec%0d.busy", i),        32'(busy), 32'(vq[i].bz));
      if (vq[i].fv) begin
        check($sformatf("vec%0d.feat_weight", i), 32'(feat_weight), 32'(vq[i].w));
        check($sformatf("vec%0d.feat_idx", i),    32'(feat_idx), 32'(vq[i].idx));
        check($sformatf("vec%0d.feat_last", i),   32'(feat_last), 32'(vq[i].last));
      end
    end

    // Backpressure: five stall cycles right after accept.
    tick();
    start_valid = 1'b1; start_base = 8'h78; start_count = 9'd3; feat_ready = 1'b0;
    @(negedge clk);
    check("bp.start_ready", 32'(start_ready), 1);
    reads = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start_valid = 1'b0; feat_ready = 1'b0;
      @(negedge clk);
      if (rom_en) reads++;
      if (k >= 2) begin
        check("bp.stall_valid", 32'(feat_valid), 1);
        check("bp.stall_weight", 32'(feat_weight), 2);
        check("bp.stall_idx", 32'(feat_idx), 32'h78);
        check("bp.stall_last", 32'(feat_last), 0);
      end
    end
    check("bp.reads_in_stall", 32'(reads), 2);
    collect("bp", 20);
    check("bp.beats", 32'(got_idx.size()), 3);
    for (int i = 0; i < 3 && i < got_idx.size(); i++) begin
      check($sformatf("bp.idx%0d", i), 32'(got_idx[i]), 32'(8'h78 + i));
      check($sformatf("bp.weight%0d", i), 32'(got_w[i]), 2);
      check($sformatf("bp.last%0d", i), 32'(got_last[i]), 32'(i == 2));
    end

    // Reset two cycles into a long stage.
    tick();
    start_valid = 1'b1; start_base = 8'h30; start_count = 9'd10; feat_ready = 1'b1;
    @(negedge clk);
    check("mrst.start_ready", 32'(start_ready), 1);
    tick();
    start_valid = 1'b0;
    @(negedge clk);
    check("mrst.running", 32'(busy), 1);
    tick();
    rst = 1'b1;
    #1;
    check_reset("mrst");
    @(negedge clk);
    check("mrst.hold_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst.rel_ready", 32'(start_ready), 0);
    check("mrst.rel_done", 32'(done), 0);
    tick();
    start_valid = 1'b1; start_base = 8'h46; start_count = 9'd1;
    @(negedge clk);
    check("mrst.ready_again", 32'(start_ready), 1);
    check("mrst.no_done", 32'(done), 0);
    collect("mrst", 20);
    check("mrst.beats", 32'(got_idx.size()), 1);
    if (got_idx.size() > 0) begin
      check("mrst.idx", 32'(got_idx[0]), 32'h46);
      check("mrst.weight", 32'(got_w[0]), 2);
      check("mrst.last", 32'(got_last[0]), 1);
    end

    run_random(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
